coeff_bank_loader: RTL

COEFF_BANK_LOADER -- requirements
Module: coeff_bank_loader

---
 rtl/coeff_loader_pkg.sv | 36 +++
 rtl/coeff_row_assembler.sv | 54 +++++
 rtl/coeff_bank_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/coeff_loader_pkg.sv
// Shared types and helpers for the coefficient bank loader: FSM state encoding,
// CRC-8 polynomial, and the beats-per-row / residual-width arithmetic.
package coeff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_FULL    = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_OUT  = 3'd6,
        ST_RD_DONE = 3'd7
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic int calc_beats(input int word_w, input int in_w);
        return (word_w + in_w - 1) / in_w;
    endfunction

    // Width of the final beat of a row; equals in_w when word_w divides evenly.
    function automatic int calc_res(input int word_w, input int in_w);
        return word_w - (calc_beats(word_w, in_w) - 1) * in_w;
    endfunction

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/coeff_row_assembler.sv
// Collects GPIO beats into one coefficient row by left-shifting; the final beat
// of a row shifts in only its residual low bits so the first beat lands in the MSBs.
module coeff_row_assembler
    import coeff_loader_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int WORD_W = 306
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              clear,
    input  logic              accept,
    input  logic [IN_W-1:0]   beat,
    output logic [WORD_W-1:0] row,
    output logic              last_beat
);

    localparam int BEATS = calc_beats(WORD_W, IN_W);
    localparam int RES   = calc_res(WORD_W, IN_W);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]     cnt_reg;
    logic [WORD_W-1:0] row_reg;
    logic [WORD_W-1:0] row_next;

    assign last_beat = (cnt_reg == CW'(BEATS - 1));
    assign row       = row_reg;

    generate
        if (BEATS > 1) begin : g_multi
            always_comb begin
                row_next = last_beat ? {row_reg[WORD_W-RES-1:0], beat[RES-1:0]}
                                     : {row_reg[WORD_W-IN_W-1:0], beat};
            end
        end else begin : g_single
            always_comb begin
                row_next = beat[WORD_W-1:0];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_reg <= '0;
            row_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (accept) begin
            row_reg <= row_next;
            cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/coeff_bank_loader.sv
// Loads a coefficient register file row by row from a GPIO beat stream, then
// streams the rows back out. Define COEFF_BANK_LOADER_CRC_EN for a CRC-8 over accepted beats.
module coeff_bank_loader
    import coeff_loader_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int WORD_W = 306,
    parameter int DEPTH  = 50,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_reset,
    input  logic              i_cmd_init,
    input  logic              i_cmd_load,
    input  logic [IN_W-1:0]   i_gpio_data,
    input  logic              i_gpio_valid,
    output logic              o_gpio_ready,
    output logic [AW-1:0]     o_mem_a,
    output logic              o_mem_web,
    output logic [WORD_W-1:0] o_mem_bweb,
    output logic [WORD_W-1:0] o_mem_d,
    input  logic [WORD_W-1:0] i_mem_q,
    output logic              o_row_valid,
    input  logic              i_row_ready,
    output logic [WORD_W-1:0] o_row_data,
    output logic [AW-1:0]     o_row_idx,
    output logic              o_wr_done,
    output logic              o_buf_full,
    output logic              o_rd_done,
    output logic [7:0]        o_crc
);

    // Pointers need one extra code so they can rest at DEPTH.
    localparam int PW = $clog2(DEPTH + 1);

    state_t            state_reg, state_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic              wr_done_reg, rd_done_reg, cmd_reset_q;
    logic [WORD_W-1:0] row_data_reg, asm_row;
    logic [AW-1:0]     row_idx_reg;
    logic              soft_clr, beat_accept, asm_clear, last_beat;
    logic              row_hs, wr_last, rd_last;

    assign soft_clr     = i_cmd_reset & ~cmd_reset_q;
    assign o_gpio_ready = (state_reg == ST_FILL) && i_cmd_init && !soft_clr;
    assign beat_accept  = i_gpio_valid && o_gpio_ready;
    assign asm_clear    = soft_clr || ((state_reg == ST_FILL) && !i_cmd_init);
    assign row_hs       = (state_reg == ST_RD_OUT) && i_row_ready;
    assign wr_last      = (wr_ptr_reg == PW'(DEPTH - 1));
    assign rd_last      = (rd_ptr_reg == PW'(DEPTH - 1));

    coeff_row_assembler #(
        .IN_W   (IN_W),
        .WORD_W (WORD_W)
    ) u_assembler (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .clear     (asm_clear),
        .accept    (beat_accept),
        .beat      (i_gpio_data),
        .row       (asm_row),
        .last_beat (last_beat)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_cmd_init && !wr_done_reg)
                    state_next = ST_FILL;
                else if (i_cmd_load && wr_done_reg)
                    state_next = ST_RD_REQ;
            end
            ST_FILL: begin
                if (!i_cmd_init)
                    state_next = ST_IDLE;
                else if (beat_accept && last_beat)
                    state_next = ST_WRITE;
            end
            ST_WRITE:   state_next = wr_last ? ST_FULL : ST_FILL;
            ST_FULL:    if (i_cmd_load) state_next = ST_RD_REQ;
            ST_RD_REQ:  state_next = i_cmd_load ? ST_RD_WAIT : ST_FULL;
            ST_RD_WAIT: state_next = i_cmd_load ? ST_RD_OUT : ST_FULL;
            // An offered row is always handed over before load-drop is honoured.
            ST_RD_OUT: begin
                if (row_hs)
                    state_next = rd_last ? ST_RD_DONE : (i_cmd_load ? ST_RD_REQ : ST_FULL);
            end
            ST_RD_DONE: state_next = ST_RD_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            wr_done_reg  <= 1'b0;
            rd_done_reg  <= 1'b0;
            cmd_reset_q  <= 1'b0;
            row_data_reg <= '0;
            row_idx_reg  <= '0;
        end else begin
            cmd_reset_q <= i_cmd_reset;
            if (soft_clr) begin
                state_reg    <= ST_IDLE;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                wr_done_reg  <= 1'b0;
                rd_done_reg  <= 1'b0;
                row_data_reg <= '0;
                row_idx_reg  <= '0;
            end else begin
                state_reg <= state_next;
                if (state_reg == ST_WRITE) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (wr_last)
                        wr_done_reg <= 1'b1;
                end
                if (state_reg == ST_RD_WAIT) begin
                    row_data_reg <= i_mem_q;
                    row_idx_reg  <= rd_ptr_reg[AW-1:0];
                end
                if (row_hs) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (rd_last)
                        rd_done_reg <= 1'b1;
                end
            end
        end
    end

    assign o_mem_web   = (state_reg != ST_WRITE);
    assign o_mem_bweb  = {WORD_W{o_mem_web}};
    assign o_mem_a     = o_mem_web ? rd_ptr_reg[AW-1:0] : wr_ptr_reg[AW-1:0];
    assign o_mem_d     = asm_row;
    assign o_row_valid = (state_reg == ST_RD_OUT);
    assign o_row_data  = row_data_reg;
    assign o_row_idx   = row_idx_reg;
    assign o_wr_done   = wr_done_reg;
    assign o_rd_done   = rd_done_reg;
    assign o_buf_full  = (wr_ptr_reg == PW'(DEPTH));

`ifdef COEFF_BANK_LOADER_CRC_EN
    logic [7:0] crc_reg;
    logic [7:0] crc_byte;

    generate
        if (IN_W >= 8) begin : g_crc_wide
            assign crc_byte = i_gpio_data[7:0];
        end else begin : g_crc_narrow
            assign crc_byte = {{(8 - IN_W){1'b0}}, i_gpio_data};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            crc_reg <= 8'h00;
        else if (soft_clr)
            crc_reg <= 8'h00;
        else if (beat_accept)
            crc_reg <= crc8_update(crc_reg, crc_byte);
    end

    assign o_crc = crc_reg;
`else
    assign o_crc = 8'h00;
`endif

endmodule
